serial_burst_seq: RTL and testbench
===================================

// Module: serial_burst_seq
// PURPOSE
//  Multi-word burst sequencer directly upstream of the 3-wire serial controller.
//  - Streams a host-loaded TX FIFO into the controller's enable/parallel inputs, one word per serial word.
//  - Captures each word shifted back from the IC into an RX FIFO.
//  - Runs entirely in the serial clock domain; the host side must be synchronous to serial_clk.
// PARAMETERS
//  BITS       8    word width; must equal the controller's BITS
//  TX_DEPTH   16   TX FIFO entries (power of 2)
//  RX_DEPTH   16   RX FIFO entries (power of 2)
//  MAX_WORDS  255  max burst length; NW = $clog2(MAX_WORDS+1)
// PORTS
//  serial_clk            in   1          serial clock (controller's raw clock); all flops on rising edge
//  in_rst                in   1          reset, asynchronous, active-high
//  in_tx_wr              in   1          push in_tx_data into TX FIFO
//  in_tx_data            in   BITS       TX word
//  out_tx_full           out  1          TX FIFO full
//  out_tx_level          out  clog2(TX_DEPTH)+1  TX FIFO occupancy
//  in_start              in   1          start burst (sampled in Idle only)
//  in_num_words          in   NW         burst length, sampled with in_start
//  out_busy              out  1          state != Idle
//  out_done              out  1          1-cycle pulse at burst end
//  out_err_underrun      out  1          sticky: TX FIFO ran dry mid-burst
//  out_err_overflow      out  1          sticky: RX word dropped (RX FIFO full)
//  in_rx_rd              in   1          pop RX FIFO
//  out_rx_data           out  BITS       RX FIFO head (show-ahead)
//  out_rx_empty          out  1          RX FIFO empty
//  out_ser_enable        out  1          -> controller in_enable
//  out_ser_parallel      out  BITS       -> controller in_parallel (registered)
//  in_ser_ready          in   1          <- controller out_ready
//  in_ser_next_word      in   1          <- controller out_next_word (high during last bit)
//  in_ser_word_finished  in   1          <- controller out_word_finished
//  in_ser_parallel       in   BITS       <- controller out_parallel
// BEHAVIOUR
//  - Reset: state Idle, both FIFOs empty, all outputs 0 except out_rx_empty=1.
//    Reset mid-burst aborts immediately: out_ser_enable=0, no out_done.
//  - Rising-edge clocking places updates mid-bit, between controller falling edges;
//    out_ser_parallel must therefore never change except in the last-bit period.
//  - FSM Idle: in_start & in_ser_ready & in_num_words!=0 & TX non-empty
//      -> Run: pop TX head into out_ser_parallel, remaining=in_num_words-1, enable=1,
//         clear both error flags.
//  - Idle: in_start with in_num_words==0 -> stay Idle, out_done pulse next cycle.
//  - Idle: in_start with TX empty -> stay Idle, out_err_underrun=1, out_done pulse.
//  - Idle: in_start with in_ser_ready=0 -> ignored.
//  - Run: edge with in_ser_next_word=1:
//      remaining>0 & TX non-empty -> pop into out_ser_parallel, remaining-1 (back-to-back words);
//      remaining>0 & TX empty     -> enable=0, out_err_underrun=1, -> Drain;
//      remaining==0               -> enable=0, -> Drain.
//  - Drain: edge with in_ser_word_finished=1 -> Idle, out_done=1 for exactly 1 cycle.
//  - in_start is ignored outside Idle.
//  - TX FIFO: writes accepted in any state incl. Run (streaming).
//    Write when full is ignored, no flag.
//    Simultaneous push+pop leaves the level unchanged.
//  - RX capture: each edge with in_ser_word_finished=1 pushes in_ser_parallel.
//    Full -> word dropped, out_err_overflow=1.
//    Full with same-edge in_rx_rd -> pop and push both take effect.
//  - FIFO pointers wrap modulo depth; level uses one extra bit to tell full from empty.
// CONFIGURATION
//  SERIAL_BURST_RX_EN defined:
//    - RX FIFO and overflow logic are built, as specified above.
//  SERIAL_BURST_RX_EN undefined:
//    - No RX storage; in_ser_parallel and in_rx_rd are ignored.
//    - out_rx_empty=1, out_rx_data=0, out_err_overflow=0 constant.
//    - TX path and FSM are unchanged.
// TESTING (bench pairs with the real serial controller, BITS=8, LSB first)
//  - Push A5,3C,0F; start n=3 -> serial line carries A5,3C,0F with no gaps;
//    enable drops during the last bit of 0F; one out_done; TX empty.
//  - IC loopback of the serial line, n=3 -> RX pops A5,3C,0F in order, then out_rx_empty=1.
//  - Push 11 only; start n=2 -> 11 sent, enable drops after word 1, out_err_underrun=1,
//    out_done pulses once.
//  - Start n=0 -> no enable, out_done pulse, errors clear.
//    Start with TX empty -> out_err_underrun=1, out_done pulse.
//  - RX_DEPTH=2, n=3, no reads -> 2 words kept, out_err_overflow=1.
//    Push 4 more words with in_tx_wr while full -> out_tx_level stays at TX_DEPTH.
//  - Assert in_rst during word 2 of 4 -> enable=0 and FIFOs empty immediately;
//    out_busy=0; no out_done.

Source files
------------

// File: rtl/serial_burst_seq.sv
// ---------------------------------------------------------------------------
// serial_burst_seq
//
// Multi-word burst sequencer that sits directly upstream of the 3-wire serial
// controller. The host loads words into a TX FIFO. On in_start the sequencer
// streams in_num_words of them into the controller's enable/parallel inputs,
// one word per serial word and with no gaps between words. Each word the
// controller shifts back in is captured into an RX FIFO. Every flop is clocked
// on the rising edge of serial_clk, so the host side must be synchronous to
// that clock.
//
// Build option:
//   SERIAL_BURST_RX_EN  defined   -> RX FIFO and overflow detection are built.
//                       undefined -> no RX storage. in_ser_parallel and
//                                    in_rx_rd are ignored, out_rx_empty=1,
//                                    out_rx_data=0 and out_err_overflow=0.
//
// Ports:
//   serial_clk            in   serial clock (controller's raw clock)
//   in_rst                in   asynchronous active-high reset
//   in_tx_wr / in_tx_data in   push a word into the TX FIFO (ignored if full)
//   out_tx_full           out  TX FIFO full
//   out_tx_level          out  TX FIFO occupancy (0..TX_DEPTH)
//   in_start              in   start a burst (sampled in Idle only)
//   in_num_words          in   burst length, sampled with in_start
//   out_busy              out  sequencer not in Idle
//   out_done              out  one-cycle pulse at burst end
//   out_err_underrun      out  sticky: TX FIFO ran dry during a burst
//   out_err_overflow      out  sticky: RX word dropped because RX FIFO full
//   in_rx_rd              in   pop the RX FIFO
//   out_rx_data           out  RX FIFO head (show-ahead, 0 when empty)
//   out_rx_empty          out  RX FIFO empty
//   out_ser_enable        out  -> controller in_enable
//   out_ser_parallel      out  -> controller in_parallel (registered)
//   in_ser_ready          in   <- controller out_ready
//   in_ser_next_word      in   <- controller out_next_word (last-bit period)
//   in_ser_word_finished  in   <- controller out_word_finished
//   in_ser_parallel       in   <- controller out_parallel (received word)
// ---------------------------------------------------------------------------
module serial_burst_seq #(
    parameter int BITS      = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int MAX_WORDS = 255,
    localparam int NW       = $clog2(MAX_WORDS + 1),
    localparam int TXA      = $clog2(TX_DEPTH)
) (
    input  logic            serial_clk,
    input  logic            in_rst,
    input  logic            in_tx_wr,
    input  logic [BITS-1:0] in_tx_data,
    output logic            out_tx_full,
    output logic [TXA:0]    out_tx_level,
    input  logic            in_start,
    input  logic [NW-1:0]   in_num_words,
    output logic            out_busy,
    output logic            out_done,
    output logic            out_err_underrun,
    output logic            out_err_overflow,
    input  logic            in_rx_rd,
    output logic [BITS-1:0] out_rx_data,
    output logic            out_rx_empty,
    output logic            out_ser_enable,
    output logic [BITS-1:0] out_ser_parallel,
    input  logic            in_ser_ready,
    input  logic            in_ser_next_word,
    input  logic            in_ser_word_finished,
    input  logic [BITS-1:0] in_ser_parallel
);

    localparam logic [TXA:0]   TX_FULL_LEVEL = (TXA + 1)'(TX_DEPTH);
    localparam logic [TXA:0]   TX_LVL_ONE    = (TXA + 1)'(1);
    localparam logic [TXA-1:0] TX_PTR_ONE    = TXA'(1);
    localparam logic [NW-1:0]  NW_ONE        = NW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NW-1:0] remaining;
    logic [NW-1:0] remaining_next;
    logic          enable_next;
    logic          done_next;
    logic          underrun_set;
    logic          errors_clear;
    logic          overflow_set;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [BITS-1:0] tx_mem [TX_DEPTH];
    logic [TXA-1:0]  tx_wr_ptr;
    logic [TXA-1:0]  tx_rd_ptr;
    logic [TXA:0]    tx_level;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_push;
    logic            tx_pop;

    assign tx_full      = (tx_level == TX_FULL_LEVEL);
    assign tx_empty     = (tx_level == '0);
    assign tx_push      = in_tx_wr & ~tx_full;
    assign out_tx_full  = tx_full;
    assign out_tx_level = tx_level;

    // Storage has no reset. Only the pointers and the level define what is valid.
    always_ff @(posedge serial_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= in_tx_data;
        end
    end

    // Push and pop on the same edge cancel in the level.
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            end
            if (tx_push && !tx_pop) begin
                tx_level <= tx_level + TX_LVL_ONE;
            end else if (!tx_push && tx_pop) begin
                tx_level <= tx_level - TX_LVL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: next state and datapath controls.
    // The next word is handed over only on the edge where the controller
    // flags its last bit. That edge falls mid-bit, so out_ser_parallel is
    // stable before the controller's falling-edge load of the next word.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        tx_pop         = 1'b0;
        remaining_next = remaining;
        enable_next    = out_ser_enable;
        done_next      = 1'b0;
        underrun_set   = 1'b0;
        errors_clear   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (in_start && in_ser_ready) begin
                    if (in_num_words == '0) begin
                        done_next    = 1'b1;
                        errors_clear = 1'b1;
                    end else if (tx_empty) begin
                        done_next    = 1'b1;
                        underrun_set = 1'b1;
                    end else begin
                        tx_pop         = 1'b1;
                        remaining_next = in_num_words - NW_ONE;
                        enable_next    = 1'b1;
                        errors_clear   = 1'b1;
                        state_next     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (in_ser_next_word) begin
                    if (remaining != '0) begin
                        if (!tx_empty) begin
                            tx_pop         = 1'b1;
                            remaining_next = remaining - NW_ONE;
                        end else begin
                            enable_next  = 1'b0;
                            underrun_set = 1'b1;
                            state_next   = ST_DRAIN;
                        end
                    end else begin
                        enable_next = 1'b0;
                        state_next  = ST_DRAIN;
                    end
                end
            end

            // Wait for the final word to finish shifting before reporting done.
            ST_DRAIN: begin
                if (in_ser_word_finished) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                enable_next = 1'b0;
            end
        endcase
    end

    assign out_busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Registered controller drive, burst counter, done pulse, underrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            out_ser_enable   <= 1'b0;
            out_ser_parallel <= '0;
            remaining        <= '0;
            out_done         <= 1'b0;
            out_err_underrun <= 1'b0;
        end else begin
            out_ser_enable <= enable_next;
            remaining      <= remaining_next;
            out_done       <= done_next;
            if (tx_pop) begin
                out_ser_parallel <= tx_mem[tx_rd_ptr];
            end
            if (underrun_set) begin
                out_err_underrun <= 1'b1;
            end else if (errors_clear) begin
                out_err_underrun <= 1'b0;
            end
        end
    end

`ifdef SERIAL_BURST_RX_EN
    // ------------------------------------------------------------------
    // RX FIFO. A word that arrives while the FIFO is full is dropped,
    // unless a pop on the same edge frees a slot.
    // ------------------------------------------------------------------
    localparam int             RXA           = $clog2(RX_DEPTH);
    localparam logic [RXA:0]   RX_FULL_LEVEL = (RXA + 1)'(RX_DEPTH);
    localparam logic [RXA:0]   RX_LVL_ONE    = (RXA + 1)'(1);
    localparam logic [RXA-1:0] RX_PTR_ONE    = RXA'(1);

    logic [BITS-1:0] rx_mem [RX_DEPTH];
    logic [RXA-1:0]  rx_wr_ptr;
    logic [RXA-1:0]  rx_rd_ptr;
    logic [RXA:0]    rx_level;
    logic            rx_full;
    logic            rx_empty;
    logic            rx_push;
    logic            rx_pop;

    assign rx_full      = (rx_level == RX_FULL_LEVEL);
    assign rx_empty     = (rx_level == '0);
    assign rx_pop       = in_rx_rd & ~rx_empty;
    assign rx_push      = in_ser_word_finished & (~rx_full | rx_pop);
    assign overflow_set = in_ser_word_finished & rx_full & ~rx_pop;

    // The stale head is masked so an empty FIFO reads as zero.
    assign out_rx_empty = rx_empty;
    assign out_rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    always_ff @(posedge serial_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= in_ser_parallel;
        end
    end

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            end
            if (rx_push && !rx_pop) begin
                rx_level <= rx_level + RX_LVL_ONE;
            end else if (!rx_push && rx_pop) begin
                rx_level <= rx_level - RX_LVL_ONE;
            end
        end
    end

    // A drop on the same edge as a burst start still gets reported.
    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            out_err_overflow <= 1'b0;
        end else if (overflow_set) begin
            out_err_overflow <= 1'b1;
        end else if (errors_clear) begin
            out_err_overflow <= 1'b0;
        end
    end
`else
    // Receive path absent: the controller's return data and the read strobe
    // are deliberately left unconsumed.
    localparam int RX_DEPTH_UNUSED = RX_DEPTH;
    logic rx_inputs_unused;

    assign rx_inputs_unused = ^{in_rx_rd, in_ser_parallel};
    assign overflow_set     = 1'b0;
    assign out_rx_empty     = 1'b1;
    assign out_rx_data      = '0;
    assign out_err_overflow = overflow_set;
`endif

endmodule

// File: tb/tb_serial_burst_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_burst_seq
//
// Drives serial_burst_seq against a behavioural model of the 3-wire serial
// controller (falling-edge shifting, LSB first, IC loopback on the data line).
// Expected results come from a queue-based model of the TX/RX FIFOs and the
// burst rules.
// ---------------------------------------------------------------------------
module tb_serial_burst_seq;

   localparam int BITS      = 8;
   localparam int TX_DEPTH  = 8;
   localparam int RX_DEPTH  = 4;
   localparam int MAX_WORDS = 255;

   logic       serial_clk = 1'b0;
   logic       in_rst;
   logic       in_tx_wr;
   logic [7:0] in_tx_data;
   logic       out_tx_full;
   logic [3:0] out_tx_level;
   logic       in_start;
   logic [7:0] in_num_words;
   logic       out_busy;
   logic       out_done;
   logic       out_err_underrun;
   logic       out_err_overflow;
   logic       in_rx_rd;
   logic [7:0] out_rx_data;
   logic       out_rx_empty;
   logic       out_ser_enable;
   logic [7:0] out_ser_parallel;

   // Controller model state
   logic       ctl_active;
   logic [2:0] ctl_bit;
   logic [7:0] ctl_sr;
   logic [7:0] ctl_acc;
   logic [7:0] ctl_rx;
   logic       ctl_ready;
   logic       ctl_finished;
   logic       ctl_next_word;
   logic       ctl_sdo;
   logic [7:0] line_w;
   int         ctl_starts;
   logic [7:0] sent_q[$];

   // Reference model and bookkeeping
   logic [7:0] tx_model[$];
   logic [7:0] rx_model[$];
   logic       exp_u;
   logic       exp_o;
   int         n_checks;
   int         n_fail;
   int         done_cnt;
   int         par_viol;
   logic [7:0] last_par;
   logic       par_ok;

   serial_burst_seq #(
      .BITS      (BITS),
      .TX_DEPTH  (TX_DEPTH),
      .RX_DEPTH  (RX_DEPTH),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .serial_clk           (serial_clk),
      .in_rst               (in_rst),
      .in_tx_wr             (in_tx_wr),
      .in_tx_data           (in_tx_data),
      .out_tx_full          (out_tx_full),
      .out_tx_level         (out_tx_level),
      .in_start             (in_start),
      .in_num_words         (in_num_words),
      .out_busy             (out_busy),
      .out_done             (out_done),
      .out_err_underrun     (out_err_underrun),
      .out_err_overflow     (out_err_overflow),
      .in_rx_rd             (in_rx_rd),
      .out_rx_data          (out_rx_data),
      .out_rx_empty         (out_rx_empty),
      .out_ser_enable       (out_ser_enable),
      .out_ser_parallel     (out_ser_parallel),
      .in_ser_ready         (ctl_ready),
      .in_ser_next_word     (ctl_next_word),
      .in_ser_word_finished (ctl_finished),
      .in_ser_parallel      (ctl_rx)
   );

   always #5 serial_clk = ~serial_clk;

   // The IC loops the serial line back, so each shifted-in bit is the bit sent
   assign ctl_sdo       = ctl_sr[ctl_bit];
   assign line_w        = {ctl_sdo, ctl_acc[7:1]};
   assign ctl_next_word = ctl_active && (ctl_bit == 3'd7);

   // Controller model: one bit per clock period starting at a falling edge.
   // A new word is loaded at the falling edge that ends the previous one if
   // enable is still high, which gives gap-free back-to-back words.
   always @(negedge serial_clk or posedge in_rst) begin
      if (in_rst) begin
         ctl_active   <= 1'b0;
         ctl_bit      <= 3'd0;
         ctl_sr       <= 8'h00;
         ctl_acc      <= 8'h00;
         ctl_rx       <= 8'h00;
         ctl_ready    <= 1'b1;
         ctl_finished <= 1'b0;
      end else begin
         ctl_finished <= 1'b0;
         if (ctl_active) begin
            ctl_acc <= line_w;
         end
         if (ctl_active && ctl_bit == 3'd7) begin
            ctl_finished <= 1'b1;
            ctl_rx       <= line_w;
            sent_q.push_back(line_w);
            if (out_ser_enable) begin
               ctl_sr  <= out_ser_parallel;
               ctl_bit <= 3'd0;
            end else begin
               ctl_active <= 1'b0;
               ctl_ready  <= 1'b1;
            end
         end else if (ctl_active) begin
            ctl_bit <= ctl_bit + 3'd1;
         end else if (out_ser_enable) begin
            ctl_sr     <= out_ser_parallel;
            ctl_bit    <= 3'd0;
            ctl_active <= 1'b1;
            ctl_ready  <= 1'b0;
            ctl_starts <= ctl_starts + 1;
         end
      end
   end

   // Tracks done pulses, and flags any change of the parallel word while
   // the controller is mid-word outside its last-bit period.
   always begin
      @(posedge serial_clk);
      par_ok = !ctl_active || ctl_next_word;
      #1;
      if (out_ser_parallel !== last_par && !par_ok) par_viol++;
      last_par = out_ser_parallel;
      if (out_done === 1'b1) done_cnt++;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge serial_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // RX side of the reference model: store if room, otherwise record a drop
   task automatic modelRx(input logic [7:0] w);
`ifdef SERIAL_BURST_RX_EN
      if (rx_model.size() < RX_DEPTH) rx_model.push_back(w);
      else exp_o = 1'b1;
`else
      w = w;
`endif
   endtask

   task automatic pushWord(input logic [7:0] w);
      in_tx_wr   = 1'b1;
      in_tx_data = w;
      tick();
      in_tx_wr   = 1'b0;
      if (tx_model.size() < TX_DEPTH) tx_model.push_back(w);
      checkOutput("tx_level_push", out_tx_level, tx_model.size());
   endtask

   task automatic readRx(input int cnt);
      for (int k = 0; k < cnt; k++) begin
         checkOutput("rx_empty", out_rx_empty, rx_model.size() == 0);
         checkOutput("rx_data", out_rx_data, (rx_model.size() > 0) ? rx_model[0] : 8'h00);
         in_rx_rd = 1'b1;
         tick();
         in_rx_rd = 1'b0;
         if (rx_model.size() > 0) void'(rx_model.pop_front());
      end
   endtask

   // Runs one burst of n words and checks the outcome against the model.
   task automatic applyStimulus(input int n);
      logic [7:0] exp_sent[$];
      int         d0;
      int         s0;
      int         limit;
      logic       got;
      int         avail;
      avail = tx_model.size();
      if (n == 0) begin
         exp_u = 1'b0;
         exp_o = 1'b0;
      end else if (avail == 0) begin
         exp_u = 1'b1;
      end else begin
         exp_u = (n > avail);
         exp_o = 1'b0;
         while (exp_sent.size() < n && tx_model.size() > 0) begin
            exp_sent.push_back(tx_model.pop_front());
            modelRx(exp_sent[exp_sent.size() - 1]);
         end
      end
      d0 = done_cnt;
      s0 = ctl_starts;
      sent_q.delete();
      in_start     = 1'b1;
      in_num_words = 8'(n);
      tick();
      in_start = 1'b0;
      limit = (n + 4) * BITS * 2;
      got   = out_done;
      for (int c = 0; c < limit && !got; c++) begin
         tick();
         got = out_done;
      end
      checkOutput("done_seen", got, 1);
      repeat (3) tick();
      checkOutput("done_count", done_cnt - d0, 1);
      checkOutput("ctl_starts", ctl_starts - s0, exp_sent.size() > 0);
      checkOutput("sent_count", sent_q.size(), exp_sent.size());
      foreach (exp_sent[i]) begin
         if (i < sent_q.size()) checkOutput("sent_word", sent_q[i], exp_sent[i]);
      end
      checkOutput("underrun", out_err_underrun, exp_u);
      checkOutput("overflow", out_err_overflow, exp_o);
      checkOutput("tx_level", out_tx_level, tx_model.size());
      checkOutput("tx_full", out_tx_full, tx_model.size() == TX_DEPTH);
      checkOutput("busy_end", out_busy, 0);
      checkOutput("enable_end", out_ser_enable, 0);
   endtask

   initial begin
      logic got;
      int   d0;
      int   n;
      n_checks     = 0;
      n_fail       = 0;
      done_cnt     = 0;
      par_viol     = 0;
      last_par     = 8'h00;
      ctl_starts   = 0;
      exp_u        = 1'b0;
      exp_o        = 1'b0;
      in_rst       = 1'b1;
      in_tx_wr     = 1'b0;
      in_tx_data   = 8'h00;
      in_start     = 1'b0;
      in_num_words = 8'h00;
      in_rx_rd     = 1'b0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_busy", out_busy, 0);
      checkOutput("rst_done", out_done, 0);
      checkOutput("rst_underrun", out_err_underrun, 0);
      checkOutput("rst_overflow", out_err_overflow, 0);
      checkOutput("rst_tx_full", out_tx_full, 0);
      checkOutput("rst_tx_level", out_tx_level, 0);
      checkOutput("rst_rx_empty", out_rx_empty, 1);
      checkOutput("rst_rx_data", out_rx_data, 0);
      checkOutput("rst_enable", out_ser_enable, 0);
      checkOutput("rst_parallel", out_ser_parallel, 0);
      in_rst = 1'b0;
      repeat (2) tick();

      $display("[TB] three-word burst");
      pushWord(8'hA5);
      pushWord(8'h3C);
      pushWord(8'h0F);
      applyStimulus(3);
      readRx(4);

      $display("[TB] underrun mid-burst");
      pushWord(8'h11);
      applyStimulus(2);
      readRx(2);

      $display("[TB] zero-length and empty-FIFO starts");
      applyStimulus(0);
      applyStimulus(5);

      $display("[TB] streaming push during burst");
      d0 = done_cnt;
      sent_q.delete();
      pushWord(8'hC1);
      in_start     = 1'b1;
      in_num_words = 8'd3;
      in_tx_wr     = 1'b1;
      in_tx_data   = 8'hC2;
      tick();
      in_start = 1'b0;
      in_tx_wr = 1'b0;
      checkOutput("pp_start_level", out_tx_level, 1);
      checkOutput("pp_busy", out_busy, 1);
      got = 1'b0;
      for (int c = 0; c < 4 * BITS && !got; c++) begin
         @(negedge serial_clk);
         #1;
         got = ctl_next_word;
      end
      checkOutput("pp_next_word_seen", got, 1);
      in_tx_wr   = 1'b1;
      in_tx_data = 8'hC3;
      tick();
      in_tx_wr = 1'b0;
      checkOutput("pp_mid_level", out_tx_level, 1);
      got = 1'b0;
      for (int c = 0; c < 8 * BITS && !got; c++) begin
         tick();
         got = out_done;
      end
      repeat (3) tick();
      tx_model.delete();
      exp_u = 1'b0;
      exp_o = 1'b0;
      modelRx(8'hC1);
      modelRx(8'hC2);
      modelRx(8'hC3);
      checkOutput("pp_done_count", done_cnt - d0, 1);
      checkOutput("pp_sent_count", sent_q.size(), 3);
      checkOutput("pp_sent0", (sent_q.size() > 0) ? sent_q[0] : 8'h00, 8'hC1);
      checkOutput("pp_sent1", (sent_q.size() > 1) ? sent_q[1] : 8'h00, 8'hC2);
      checkOutput("pp_sent2", (sent_q.size() > 2) ? sent_q[2] : 8'h00, 8'hC3);
      checkOutput("pp_underrun", out_err_underrun, 0);
      checkOutput("pp_level_end", out_tx_level, 0);
      readRx(4);

      $display("[TB] TX full and RX overflow");
      for (int i = 0; i < TX_DEPTH + 4; i++) pushWord(8'($urandom_range(0, 255)));
      checkOutput("full_level", out_tx_level, TX_DEPTH);
      checkOutput("full_flag", out_tx_full, 1);
      applyStimulus(TX_DEPTH);
      readRx(RX_DEPTH + 1);

      $display("[TB] randomized bursts");
      for (int it = 0; it < 30; it++) begin
         int pushes;
         pushes = $urandom_range(0, TX_DEPTH + 1);
         for (int p = 0; p < pushes; p++) pushWord(8'($urandom_range(0, 255)));
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
         applyStimulus(n);
         readRx($urandom_range(0, RX_DEPTH + 1));
      end
      readRx(RX_DEPTH + 1);

      $display("[TB] reset during word 2 of 4");
      pushWord(8'h21);
      pushWord(8'h42);
      pushWord(8'h63);
      pushWord(8'h84);
      d0 = done_cnt;
      sent_q.delete();
      in_start     = 1'b1;
      in_num_words = 8'd4;
      tick();
      in_start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 4 * BITS && !got; c++) begin
         tick();
         got = (sent_q.size() == 1);
      end
      checkOutput("rst_word2_reached", got, 1);
      repeat (3) tick();
      #2 in_rst = 1'b1;
      #1;
      checkOutput("midrst_enable", out_ser_enable, 0);
      checkOutput("midrst_busy", out_busy, 0);
      checkOutput("midrst_tx_level", out_tx_level, 0);
      checkOutput("midrst_rx_empty", out_rx_empty, 1);
      tick();
      in_rst = 1'b0;
      tx_model.delete();
      rx_model.delete();
      exp_u = 1'b0;
      exp_o = 1'b0;
      repeat (40) tick();
      checkOutput("midrst_no_done", done_cnt - d0, 0);
      checkOutput("midrst_enable_after", out_ser_enable, 0);
      checkOutput("midrst_words_sent", sent_q.size(), 1);

      $display("[TB] recovery burst");
      pushWord(8'h5A);
      pushWord(8'hE7);
      applyStimulus(2);
      readRx(3);

      checkOutput("parallel_stable", par_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
